// File: rtl/display_driver_pkg.sv
// Shared encodings, segment table and sizing constants for the display driver slice.
package display_driver_pkg;

  typedef enum logic {RX_IDLE, RX_SHIFT} rx_state_t;
  typedef enum logic {CV_IDLE, CV_CONV} cv_state_t;

  localparam int unsigned NUM_DIGITS = 3;
  localparam int unsigned FRAME_LEN  = 8;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_TABLE [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    seg_of = (d < 4'd10) ? SEG_TABLE[d] : SEG_BLANK;
  endfunction

endpackage

// File: rtl/display_driver_bin2bcd_seq.sv
// 8-bit sequential double-dabble: one add-3/shift iteration per clock, eight in total.
module bin2bcd_seq
  import display_driver_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] hun,
  output logic [3:0] ten,
  output logic [3:0] one
);

  cv_state_t   state;
  logic [7:0]  bin_sr;
  logic [11:0] bcd;
  logic [11:0] adj;
  logic [11:0] nxt;
  logic [2:0]  iter;

  always_comb begin
    adj = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    nxt = {adj[10:0], bin_sr[7]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= CV_IDLE;
      bin_sr <= '0;
      bcd    <= '0;
      iter   <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      hun    <= '0;
      ten    <= '0;
      one    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        CV_IDLE: begin
          if (start) begin
            bin_sr <= bin;
            bcd    <= '0;
            iter   <= '0;
            busy   <= 1'b1;
            state  <= CV_CONV;
          end
        end
        CV_CONV: begin
          bcd    <= nxt;
          bin_sr <= {bin_sr[6:0], 1'b0};
          iter   <= iter + 3'd1;
          if (iter == 3'd7) begin
            hun   <= nxt[11:8];
            ten   <= nxt[7:4];
            one   <= nxt[3:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= CV_IDLE;
          end
        end
        default: state <= CV_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/display_driver.sv
// Serial frame receiver feeding a BCD converter and a multiplexed 3-digit 7-segment display.
module display_driver
  import display_driver_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ser_vld,
  input  logic       ser_dat,
  output logic [7:0] byte_out,
  output logic       busy,
  output logic       frame_done,
  output logic       frame_err,
  output logic [6:0] seg,
  output logic [2:0] an
);

  rx_state_t  rx_state;
  logic [7:0] shreg;
  logic [3:0] bit_cnt;
  logic       commit_edge;
  logic       start;
  logic       err_now;
  logic       err_q;
  logic       err_pend;
  logic [3:0] hun, ten, one;
  logic [15:0] ref_cnt;
  logic [1:0]  idx;

  assign commit_edge = (rx_state == RX_SHIFT) && !ser_vld;
  assign start   = commit_edge && (bit_cnt >= 4'(FRAME_LEN)) && !busy;
  assign err_now = commit_edge && !start;

  // A short frame ending on the conversion's final edge would pulse alongside
  // frame_done; its error pulse slips one cycle so the two never overlap.
  assign frame_err = err_pend | (err_q & ~frame_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= RX_IDLE;
      shreg    <= '0;
      bit_cnt  <= '0;
      byte_out <= '0;
      err_q    <= 1'b0;
      err_pend <= 1'b0;
    end else begin
      err_q    <= err_now;
      err_pend <= err_q & frame_done;
      if (ser_vld) begin
        shreg    <= {shreg[6:0], ser_dat};
        bit_cnt  <= (bit_cnt == 4'd15) ? bit_cnt : bit_cnt + 4'd1;
        rx_state <= RX_SHIFT;
      end else if (rx_state == RX_SHIFT) begin
        bit_cnt  <= '0;
        rx_state <= RX_IDLE;
        if (start)
          byte_out <= shreg;
      end
    end
  end

  bin2bcd_seq u_bcd (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .bin   (shreg),
    .busy  (busy),
    .done  (frame_done),
    .hun   (hun),
    .ten   (ten),
    .one   (one)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      idx     <= '0;
      an      <= 3'b001;
      seg     <= SEG_TABLE[0];
    end else begin
      if (ref_cnt == 16'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        idx     <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 16'd1;
      end
      case (idx)
        2'd0: begin
          an  <= 3'b001;
          seg <= seg_of(one);
        end
        2'd1: begin
          an  <= 3'b010;
          seg <= (hun == 4'd0 && ten == 4'd0) ? SEG_BLANK : seg_of(ten);
        end
        default: begin
          an  <= 3'b100;
          seg <= (hun == 4'd0) ? SEG_BLANK : seg_of(hun);
        end
      endcase
    end
  end

endmodule

// File: tb/tb_display_driver.sv
// Directed table-driven bench for display_driver with REFRESH_DIV=4.
module tb_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       ser_vld;
  logic       ser_dat;
  logic [7:0] byte_out;
  logic       busy;
  logic       frame_done;
  logic       frame_err;
  logic [6:0] seg;
  logic [2:0] an;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int err_cnt = 0;

  display_driver #(.REFRESH_DIV(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ser_vld    (ser_vld),
    .ser_dat    (ser_dat),
    .byte_out   (byte_out),
    .busy       (busy),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .seg        (seg),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    int          n;
    logic [7:0]  byte_exp;
    logic        err;
    logic [6:0]  sh;
    logic [6:0]  st;
    logic [6:0]  so;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (frame_err) err_cnt++;
      if (frame_done || frame_err)
        chk("done_err_exclusive", {31'd0, frame_done & frame_err}, 32'd0);
    end
  end

  // Called 1ns after a posedge; leaves ser_vld low 1ns after the last sampling edge.
  task automatic send_frame(input logic [15:0] data, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ser_vld = 1'b1;
      ser_dat = data[i];
      @(posedge clk); #1;
    end
    ser_vld = 1'b0;
    ser_dat = 1'b0;
  endtask

  task automatic check_display(input logic [6:0] sh, input logic [6:0] st, input logic [6:0] so);
    logic [2:0] seen;
    seen = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (an)
        3'b001: begin chk("seg_ones", 32'(seg), 32'(so)); seen[0] = 1'b1; end
        3'b010: begin chk("seg_tens", 32'(seg), 32'(st)); seen[1] = 1'b1; end
        3'b100: begin chk("seg_hundreds", 32'(seg), 32'(sh)); seen[2] = 1'b1; end
        default: chk("an_onehot", 32'($countones(an)), 32'd1);
      endcase
    end
    chk("digits_seen", 32'(seen), 32'd7);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_values();
    chk("rst_byte_out", 32'(byte_out), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_an", 32'(an), 32'b001);
    chk("rst_seg", 32'(seg), 32'h3F);
  endtask

  task automatic run_vec(input vec_t v);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send_frame(v.data, v.n);
    @(posedge clk); #1;
    if (v.err) begin
      chk("err_pulse", 32'(frame_err), 32'd1);
      chk("err_busy", 32'(busy), 32'd0);
      @(posedge clk); #1;
      chk("err_pulse_end", 32'(frame_err), 32'd0);
      chk("err_byte_kept", 32'(byte_out), 32'(v.byte_exp));
      chk("err_count", 32'(err_cnt - e0), 32'd1);
      chk("err_no_done", 32'(done_cnt - d0), 32'd0);
    end else begin
      for (int c = 0; c <= 9; c++) begin
        if (c == 0) chk("byte_out", 32'(byte_out), 32'(v.byte_exp));
        chk("busy_timing", 32'(busy), 32'(c < 8));
        chk("done_timing", 32'(frame_done), 32'(c == 8));
        chk("no_err", 32'(frame_err), 32'd0);
        if (c < 9) begin
          @(posedge clk); #1;
        end
      end
      chk("done_count", 32'(done_cnt - d0), 32'd1);
    end
    check_display(v.sh, v.st, v.so);
  endtask

  vec_t vecs [10];
  int d0;

  initial begin
    vecs[0] = '{16'h00A7, 9,  8'hA7, 1'b0, 7'h06, 7'h7D, 7'h07};
    vecs[1] = '{16'h0016, 5,  8'hA7, 1'b1, 7'h06, 7'h7D, 7'h07};
    vecs[2] = '{16'h0005, 9,  8'h05, 1'b0, 7'h00, 7'h00, 7'h6D};
    vecs[3] = '{16'h00FF, 9,  8'hFF, 1'b0, 7'h5B, 7'h6D, 7'h6D};
    vecs[4] = '{16'h0000, 9,  8'h00, 1'b0, 7'h00, 7'h00, 7'h3F};
    vecs[5] = '{16'h0F3C, 12, 8'h3C, 1'b0, 7'h00, 7'h7D, 7'h3F};
    vecs[6] = '{16'h000A, 8,  8'h0A, 1'b0, 7'h00, 7'h06, 7'h3F};
    vecs[7] = '{16'h007F, 7,  8'h0A, 1'b1, 7'h00, 7'h06, 7'h3F};
    vecs[8] = '{16'h0163, 9,  8'h63, 1'b0, 7'h00, 7'h6F, 7'h6F};
    vecs[9] = '{16'hFFC8, 16, 8'hC8, 1'b0, 7'h5B, 7'h3F, 7'h3F};

    rst = 1'b1;
    ser_vld = 1'b0;
    ser_dat = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Back-to-back frames with a single-cycle gap.
    d0 = done_cnt;
    send_frame(16'h00FF, 9);
    @(posedge clk); #1;
    chk("b2b_byte_ff", 32'(byte_out), 32'hFF);
    send_frame(16'h0000, 9);
    @(posedge clk); #1;
    chk("b2b_byte_00", 32'(byte_out), 32'h00);
    chk("b2b_busy", 32'(busy), 32'd1);
    repeat (9) @(posedge clk);
    #1;
    chk("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check_display(7'h00, 7'h00, 7'h3F);

    // Load a visible value, then reset partway through the next frame.
    run_vec('{16'h00C8, 9, 8'hC8, 1'b0, 7'h5B, 7'h3F, 7'h3F});
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      ser_vld = 1'b1;
      ser_dat = 1'(i % 2);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    ser_vld = 1'b0;
    #2;
    check_reset_values();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midframe_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midframe_byte", 32'(byte_out), 32'h00);
    check_display(7'h00, 7'h00, 7'h3F);

    // Reset while a conversion is in flight.
    d0 = done_cnt;
    send_frame(16'h00A7, 9);
    @(posedge clk); #1;
    chk("midconv_busy", 32'(busy), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    check_reset_values();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    chk("midconv_no_done", 32'(done_cnt - d0), 32'd0);
    check_display(7'h00, 7'h00, 7'h3F);

    run_vec('{16'h0064, 9, 8'h64, 1'b0, 7'h06, 7'h3F, 7'h3F});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
